// File: rtl/rsfq_pulse_pkg.sv
// Shared constants and helpers for the RSFQ pulse demerge block.
package rsfq_pulse_pkg;

    // Routing policies.
    localparam int ROUTE_SEL = 0;
    localparam int ROUTE_RR  = 1;

    // Legal parameter ceilings.
    localparam int MAX_DELAY = 16;
    localparam int MAX_GAP   = 15;

    // Widest counter the saturating helper supports.
    localparam int SAT_W = 32;

    // Saturating increment: holds at max_val instead of wrapping.
    function automatic logic [SAT_W-1:0] sat_inc(
        input logic [SAT_W-1:0] cnt,
        input logic [SAT_W-1:0] max_val
    );
        logic [SAT_W-1:0] res;
        res = cnt;
        if (cnt < max_val) begin
            res = cnt + {{(SAT_W-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

endpackage

// File: rtl/rsfq_pulse_demerge_delay_line.sv
// Fixed-length pulse delay line: a 1 presented on `in` appears on `out`
// exactly DEPTH cycles later. Several pulses may be in flight at once.
module rsfq_pulse_delay_line
    import rsfq_pulse_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic out
);

    if (DEPTH < 1 || DEPTH > MAX_DELAY) begin : g_bad_depth
        $fatal(1, "rsfq_pulse_delay_line: DEPTH %0d outside 1..%0d", DEPTH, MAX_DELAY);
    end

    logic [DEPTH-1:0] sr;

    // Shift pulses one stage per cycle; reset discards everything in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr <= '0;
        end else begin
            sr[0] <= in;
            for (int i = 1; i < DEPTH; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign out = sr[DEPTH-1];

endmodule

// File: rtl/rsfq_pulse_demerge.sv
// Receive side of a merged toggle-coded SFQ pulse line. Every edge of
// pulse_in is a pulse; accepted pulses are routed to out_a or out_b,
// delayed per output, and re-emitted as toggles. Pulses arriving inside
// the minimum-spacing window are dropped and flagged.
module rsfq_pulse_demerge
    import rsfq_pulse_pkg::*;
#(
    parameter int ROUTE_MODE = 0,
    parameter int DELAY_A    = 4,
    parameter int DELAY_B    = 4,
    parameter int MIN_GAP    = 3,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pulse_in,
    input  logic             sel,
    output logic             out_a,
    output logic             out_b,
    output logic             err,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b,
    output logic [CNT_W-1:0] viol_cnt
);

    // Parameter sanity: anything out of range stops elaboration.
    if (ROUTE_MODE != ROUTE_SEL && ROUTE_MODE != ROUTE_RR) begin : g_bad_mode
        $fatal(1, "rsfq_pulse_demerge: ROUTE_MODE %0d not 0 or 1", ROUTE_MODE);
    end
    if (DELAY_A < 1 || DELAY_A > MAX_DELAY) begin : g_bad_delay_a
        $fatal(1, "rsfq_pulse_demerge: DELAY_A %0d outside 1..%0d", DELAY_A, MAX_DELAY);
    end
    if (DELAY_B < 1 || DELAY_B > MAX_DELAY) begin : g_bad_delay_b
        $fatal(1, "rsfq_pulse_demerge: DELAY_B %0d outside 1..%0d", DELAY_B, MAX_DELAY);
    end
    if (MIN_GAP < 1 || MIN_GAP > MAX_GAP) begin : g_bad_gap
        $fatal(1, "rsfq_pulse_demerge: MIN_GAP %0d outside 1..%0d", MIN_GAP, MAX_GAP);
    end
    if (CNT_W < 1 || CNT_W > SAT_W) begin : g_bad_cnt_w
        $fatal(1, "rsfq_pulse_demerge: CNT_W %0d outside 1..%0d", CNT_W, SAT_W);
    end

    // Window length reloaded on each accepted pulse.
    localparam logic [3:0] GAP_LOAD = 4'(MIN_GAP);

    // All-ones ceiling for the counters, widened for the shared helper.
    localparam logic [SAT_W-1:0] CNT_MAX =
        (CNT_W == SAT_W) ? {SAT_W{1'b1}} : ((SAT_W'(1) << CNT_W) - SAT_W'(1));

    logic       prev_in;
    logic [3:0] gap_cnt;
    logic       rr_ptr;

    logic det;
    logic gap_open;
    logic accept;
    logic violate;
    logic dest_b;
    logic ins_a;
    logic ins_b;
    logic exit_a;
    logic exit_b;

    // Edge detect and legality: a pulse is legal only once the window has drained.
    assign det      = pulse_in ^ prev_in;
    assign gap_open = (gap_cnt == 4'd0);
    assign accept   = det & gap_open;
    assign violate  = det & ~gap_open;

    // Destination: sel in select mode, the alternating pointer otherwise.
    assign dest_b = (ROUTE_MODE == ROUTE_RR) ? rr_ptr : sel;
    assign ins_a  = accept & ~dest_b;
    assign ins_b  = accept & dest_b;

    // Input history, spacing window and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_in <= pulse_in;
            gap_cnt <= 4'd0;
            rr_ptr  <= 1'b0;
        end else begin
            prev_in <= pulse_in;
            if (accept) begin
                gap_cnt <= GAP_LOAD;
            end else if (gap_cnt != 4'd0) begin
                gap_cnt <= gap_cnt - 4'd1;
            end
            if (accept && ROUTE_MODE == ROUTE_RR) begin
                rr_ptr <= ~rr_ptr;
            end
        end
    end

    rsfq_pulse_delay_line #(
        .DEPTH (DELAY_A)
    ) u_line_a (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (ins_a),
        .out   (exit_a)
    );

    rsfq_pulse_delay_line #(
        .DEPTH (DELAY_B)
    ) u_line_b (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (ins_b),
        .out   (exit_b)
    );

    // Output toggles, saturating pulse counters and the sticky violation record.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_a    <= 1'b0;
            out_b    <= 1'b0;
            err      <= 1'b0;
            cnt_a    <= '0;
            cnt_b    <= '0;
            viol_cnt <= '0;
        end else begin
            if (exit_a) begin
                out_a <= ~out_a;
                cnt_a <= CNT_W'(sat_inc(SAT_W'(cnt_a), CNT_MAX));
            end
            if (exit_b) begin
                out_b <= ~out_b;
                cnt_b <= CNT_W'(sat_inc(SAT_W'(cnt_b), CNT_MAX));
            end
            if (violate) begin
                err      <= 1'b1;
                viol_cnt <= CNT_W'(sat_inc(SAT_W'(viol_cnt), CNT_MAX));
            end
        end
    end

endmodule

// File: tb/tb_rsfq_pulse_demerge.sv
// Bench for rsfq_pulse_demerge: four configurations share one stimulus
// stream; a time-scheduled reference model tracks each of them.
module tb_rsfq_pulse_demerge;

    logic clk = 1'b0;
    logic rst_n;
    logic pulse_in;
    logic sel;

    // Instance 0: defaults; 1: round robin; 2: DELAY_A=2/DELAY_B=8;
    // 3: CNT_W=4, MIN_GAP=1, DELAY_A=1, DELAY_B=16.
    logic        oa [4];
    logic        ob [4];
    logic        er [4];
    logic [15:0] ca [3];
    logic [15:0] cb [3];
    logic [15:0] vc [3];
    logic [3:0]  ca4, cb4, vc4;

    always #5 clk = ~clk;

    rsfq_pulse_demerge u_m0 (
        .clk(clk), .rst_n(rst_n), .pulse_in(pulse_in), .sel(sel),
        .out_a(oa[0]), .out_b(ob[0]), .err(er[0]),
        .cnt_a(ca[0]), .cnt_b(cb[0]), .viol_cnt(vc[0])
    );

    rsfq_pulse_demerge #(.ROUTE_MODE(1)) u_m1 (
        .clk(clk), .rst_n(rst_n), .pulse_in(pulse_in), .sel(sel),
        .out_a(oa[1]), .out_b(ob[1]), .err(er[1]),
        .cnt_a(ca[1]), .cnt_b(cb[1]), .viol_cnt(vc[1])
    );

    rsfq_pulse_demerge #(.DELAY_A(2), .DELAY_B(8)) u_dl (
        .clk(clk), .rst_n(rst_n), .pulse_in(pulse_in), .sel(sel),
        .out_a(oa[2]), .out_b(ob[2]), .err(er[2]),
        .cnt_a(ca[2]), .cnt_b(cb[2]), .viol_cnt(vc[2])
    );

    rsfq_pulse_demerge #(.CNT_W(4), .MIN_GAP(1), .DELAY_A(1), .DELAY_B(16)) u_c4 (
        .clk(clk), .rst_n(rst_n), .pulse_in(pulse_in), .sel(sel),
        .out_a(oa[3]), .out_b(ob[3]), .err(er[3]),
        .cnt_a(ca4), .cnt_b(cb4), .viol_cnt(vc4)
    );

    // ---------------- reference model configuration ----------------
    int cfg_mode [4] = '{0, 1, 0, 0};
    int cfg_da   [4] = '{4, 4, 2, 1};
    int cfg_db   [4] = '{4, 4, 8, 16};
    int cfg_gap  [4] = '{3, 3, 3, 1};
    int cfg_max  [4] = '{65535, 65535, 65535, 15};

    // ---------------- reference model state ----------------
    int  cyc = 0;
    bit  m_prev [4];
    bit  m_have [4];
    int  m_last [4];
    bit  m_rr   [4];
    bit  pend_a [4][32];
    bit  pend_b [4][32];
    bit  e_oa   [4];
    bit  e_ob   [4];
    bit  e_err  [4];
    int  e_ca   [4];
    int  e_cb   [4];
    int  e_v    [4];

    int  n_checks = 0;
    int  n_pass   = 0;
    bit  chk_en   = 1'b0;

    function automatic int sat(input int c, input int mx);
        return (c >= mx) ? mx : c + 1;
    endfunction

    function automatic logic [63:0] pk(input logic a, input logic b, input logic e,
                                       input logic [15:0] x, input logic [15:0] y,
                                       input logic [15:0] z);
        return {13'b0, a, b, e, x, y, z};
    endfunction

    function automatic logic [63:0] act_of(input int i);
        logic [63:0] r;
        case (i)
            0: r = pk(oa[0], ob[0], er[0], ca[0], cb[0], vc[0]);
            1: r = pk(oa[1], ob[1], er[1], ca[1], cb[1], vc[1]);
            2: r = pk(oa[2], ob[2], er[2], ca[2], cb[2], vc[2]);
            default: r = pk(oa[3], ob[3], er[3], {12'b0, ca4}, {12'b0, cb4}, {12'b0, vc4});
        endcase
        return r;
    endfunction

    function automatic logic [63:0] exp_of(input int i);
        return pk(e_oa[i], e_ob[i], e_err[i], 16'(e_ca[i]), 16'(e_cb[i]), 16'(e_v[i]));
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Model: each accepted pulse schedules a toggle DELAY cycles ahead.
    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < 4; i++) begin
            if (!rst_n) begin
                m_prev[i] = pulse_in;
                m_have[i] = 1'b0;
                m_rr[i]   = 1'b0;
                e_oa[i]   = 1'b0;
                e_ob[i]   = 1'b0;
                e_err[i]  = 1'b0;
                e_ca[i]   = 0;
                e_cb[i]   = 0;
                e_v[i]    = 0;
                for (int s = 0; s < 32; s++) begin
                    pend_a[i][s] = 1'b0;
                    pend_b[i][s] = 1'b0;
                end
            end else begin
                if (pend_a[i][cyc % 32]) begin
                    pend_a[i][cyc % 32] = 1'b0;
                    e_oa[i] = ~e_oa[i];
                    e_ca[i] = sat(e_ca[i], cfg_max[i]);
                end
                if (pend_b[i][cyc % 32]) begin
                    pend_b[i][cyc % 32] = 1'b0;
                    e_ob[i] = ~e_ob[i];
                    e_cb[i] = sat(e_cb[i], cfg_max[i]);
                end
                if (pulse_in != m_prev[i]) begin
                    if (!m_have[i] || (cyc - m_last[i]) > cfg_gap[i]) begin
                        bit to_b;
                        to_b = (cfg_mode[i] == 1) ? m_rr[i] : sel;
                        if (cfg_mode[i] == 1) m_rr[i] = ~m_rr[i];
                        if (to_b) pend_b[i][(cyc + cfg_db[i]) % 32] = 1'b1;
                        else      pend_a[i][(cyc + cfg_da[i]) % 32] = 1'b1;
                        m_have[i] = 1'b1;
                        m_last[i] = cyc;
                    end else begin
                        e_err[i] = 1'b1;
                        e_v[i]   = sat(e_v[i], cfg_max[i]);
                    end
                end
                m_prev[i] = pulse_in;
            end
        end
    end

    // Scoreboard: every instance against the model, mid-cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("sb_u%0d_cyc%0d", i, cyc), act_of(i), exp_of(i));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit tgl;
        bit s;
        int hold;
        bit oa;
        bit ob;
        bit er;
        int ca;
        int cb;
        int v;
    } vec_t;

    vec_t tbl [10];

    initial begin
        // Directed window/route sequence on the default instance.
        tbl[0] = '{1, 0, 0, 0, 0, 0, 0, 0, 0};  // accepted to a
        tbl[1] = '{1, 1, 0, 0, 0, 1, 0, 0, 1};  // 1 cycle later: dropped
        tbl[2] = '{0, 0, 1, 0, 0, 1, 0, 0, 1};  // quiet
        tbl[3] = '{0, 0, 0, 1, 0, 1, 1, 0, 1};  // out_a toggles 4 after accept
        tbl[4] = '{1, 1, 0, 1, 0, 1, 1, 0, 1};  // accepted to b
        tbl[5] = '{1, 0, 0, 1, 0, 1, 1, 0, 2};  // +1: dropped
        tbl[6] = '{1, 0, 0, 1, 0, 1, 1, 0, 3};  // +2: dropped
        tbl[7] = '{1, 0, 0, 1, 0, 1, 1, 0, 4};  // +3 (= MIN_GAP): dropped
        tbl[8] = '{1, 0, 0, 1, 1, 1, 1, 1, 4};  // +4: accepted to a; b toggles
        tbl[9] = '{0, 0, 3, 0, 1, 1, 2, 1, 4};  // a toggles back

        // Reset with the line held high: no pulse, everything quiet.
        pulse_in = 1'b1;
        sel      = 1'b0;
        rst_n    = 1'b0;
        tick(1);
        chk_en = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(20);
        check("reset_quiet_m0", act_of(0), pk(0, 0, 0, 0, 0, 0));
        check("reset_quiet_m1", act_of(1), pk(0, 0, 0, 0, 0, 0));

        // Table-driven sequence.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            if (tbl[k].tgl) pulse_in = ~pulse_in;
            sel = tbl[k].s;
            tick(1 + tbl[k].hold);
            check($sformatf("tbl%0d", k), act_of(0),
                  pk(tbl[k].oa, tbl[k].ob, tbl[k].er,
                     16'(tbl[k].ca), 16'(tbl[k].cb), 16'(tbl[k].v)));
        end

        // Round robin: four pulses 5 apart go a, b, a, b.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            pulse_in = ~pulse_in;
            tick(5);
        end
        tick(10);
        check("rr_counts", act_of(1), pk(0, 0, 0, 2, 2, 0));

        // Unequal delays: b at t, a at t+6 -> both toggle at t+8.
        do_reset();
        sel = 1'b1;
        pulse_in = ~pulse_in;
        tick(6);
        sel = 1'b0;
        pulse_in = ~pulse_in;
        tick(2);
        check("dl_before", act_of(2), pk(0, 0, 0, 0, 0, 0));
        tick(1);
        check("dl_same_cycle", act_of(2), pk(1, 1, 0, 1, 1, 0));

        // Reset while a pulse is in flight discards it.
        do_reset();
        sel = 1'b0;
        pulse_in = ~pulse_in;
        tick(2);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(8);
        check("reset_inflight", act_of(0), pk(0, 0, 0, 0, 0, 0));

        // 4-bit counters saturate at 15.
        do_reset();
        sel = 1'b0;
        for (int k = 0; k < 20; k++) begin
            pulse_in = ~pulse_in;
            tick(5);
        end
        tick(5);
        check("c4_saturate", {60'b0, ca4}, 64'd15);
        check("c4_state", act_of(3), pk(0, 0, 0, 16'd15, 0, 0));

        // Random traffic with occasional resets.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 2) == 0) pulse_in = ~pulse_in;
            sel   = 1'($urandom_range(0, 1));
            rst_n = ($urandom_range(0, 299) != 0);
            tick(1);
        end
        rst_n = 1'b1;
        tick(25);
        chk_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
